// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a 2-entry {pc, word} FIFO
// and a single-outstanding-request memory FSM (IDLE / WAIT / DROP).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   stop              - hazard stall, holds the FIFO head
//   br, br_target     - taken-branch redirect pulse and its target
//   imem_req/addr     - memory request and word-aligned address
//   imem_ack/rdata    - memory acknowledge and same-cycle data
//   instr/instr_pc    - head instruction and its PC (0 when empty)
//   instr_valid       - head holds a real fetched instruction
module fetch_unit #(
   parameter int              BITS     = 32,
   parameter logic [BITS-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stop,
   input  logic            br,
   input  logic [BITS-1:0] br_target,
   output logic            imem_req,
   output logic [BITS-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic [BITS-1:0] instr_pc,
   output logic            instr_valid
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [BITS-1:0] fetch_pc;
   logic [BITS-1:0] fetch_pc_nx;
   logic [BITS-1:0] addr_nx;
   logic [1:0]      count;
   logic [1:0]      count_nx;
   logic [1:0]      count_pop;
   logic [BITS-1:0] pc0;
   logic [BITS-1:0] pc1;
   logic [31:0]     w0;
   logic [31:0]     w1;
   logic            push;
   logic            pop;
   logic [BITS-1:0] tgt;
   logic [BITS-1:0] addr_inc;

   assign tgt      = br_target & ~BITS'(3);
   assign addr_inc = imem_addr + BITS'(4);
   assign pop      = (count != 2'd0) && !stop && !br;

   // Occupancy once this cycle's pop is taken; decides whether a new
   // request can be issued without risking overflow.
   assign count_pop = count - {1'b0, pop};

   always_comb begin
      state_nx    = state;
      fetch_pc_nx = fetch_pc;
      addr_nx     = imem_addr;
      push        = 1'b0;
      unique case (state)
         IDLE: begin
            if (br) begin
               fetch_pc_nx = tgt;
               addr_nx     = tgt;
               state_nx    = WAIT;
            end else if (count_pop < 2'd2) begin
               addr_nx  = fetch_pc;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (imem_ack && br) begin
               fetch_pc_nx = tgt;
               addr_nx     = tgt;
            end else if (imem_ack) begin
               push        = 1'b1;
               fetch_pc_nx = addr_inc;
               if (count_pop == 2'd0) begin
                  addr_nx = addr_inc;
               end else begin
                  state_nx = IDLE;
               end
            end else if (br) begin
               fetch_pc_nx = tgt;
               state_nx    = DROP;
            end
         end
         DROP: begin
            // The stale request must complete before a new one may issue.
            if (imem_ack) begin
               state_nx    = WAIT;
               fetch_pc_nx = br ? tgt : fetch_pc;
               addr_nx     = br ? tgt : fetch_pc;
            end else if (br) begin
               fetch_pc_nx = tgt;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      count_nx = count;
      if (br) begin
         count_nx = 2'd0;
      end else begin
         count_nx = count_pop + {1'b0, push};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_addr <= RESET_PC;
         count     <= 2'd0;
         pc0       <= '0;
         pc1       <= '0;
         w0        <= '0;
         w1        <= '0;
      end else begin
         state     <= state_nx;
         fetch_pc  <= fetch_pc_nx;
         imem_addr <= addr_nx;
         count     <= count_nx;
         if (pop && push) begin
            if (count == 2'd2) begin
               pc0 <= pc1;
               w0  <= w1;
               pc1 <= imem_addr;
               w1  <= imem_rdata;
            end else begin
               pc0 <= imem_addr;
               w0  <= imem_rdata;
            end
         end else if (pop) begin
            pc0 <= pc1;
            w0  <= w1;
         end else if (push) begin
            if (count == 2'd0) begin
               pc0 <= imem_addr;
               w0  <= imem_rdata;
            end else begin
               pc1 <= imem_addr;
               w1  <= imem_rdata;
            end
         end
      end
   end

   assign imem_req    = (state != IDLE);
   assign instr_valid = (count != 2'd0);
   assign instr       = instr_valid ? w0 : 32'h0;
   assign instr_pc    = instr_valid ? pc0 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random checks of fetch_unit against an
// architectural model of the fetched instruction stream.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stop;
   logic        br;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;

   int          total = 0;
   int          bad = 0;
   int          cnt = 0;
   bit          stale = 1'b0;
   logic [31:0] exp_pc = 32'h0;

   fetch_unit #(.BITS(32), .RESET_PC(32'h0)) dut (
      .clk(clk),
      .rst(rst),
      .stop(stop),
      .br(br),
      .br_target(br_target),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_ack(imem_ack),
      .imem_rdata(imem_rdata),
      .instr(instr),
      .instr_pc(instr_pc),
      .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a << 10) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit r, input bit s, input bit b,
                        input logic [31:0] t, input bit a);
      rst        = r;
      stop       = s;
      br         = b;
      br_target  = t;
      imem_ack   = a && imem_req;
      imem_rdata = imem_ack ? memw(imem_addr) : $urandom;
   endtask

   // One clock edge plus the stream model: the head is always the next
   // sequential PC after the last redirect, and its word is memw(pc).
   task automatic step();
      bit          pr, pv, ps, pb, pa, preq, cons, good;
      logic [31:0] pt, paddr;
      pr    = rst;
      pv    = instr_valid;
      ps    = stop;
      pb    = br;
      pa    = imem_ack;
      preq  = imem_req;
      pt    = br_target;
      paddr = imem_addr;
      @(posedge clk);
      #1;
      if (pr) begin
         cnt    = 0;
         stale  = 1'b0;
         exp_pc = 32'h0;
      end else begin
         cons = pv && !ps && !pb;
         good = pa && !pb && !stale;
         if (good) chk("ack_full", 32'((cnt - int'(cons)) < 2), 32'd1);
         if (pa) stale = 1'b0;
         else if (pb && preq) stale = 1'b1;
         if (pb) cnt = 0;
         else cnt = cnt + int'(good) - int'(cons);
         if (pb) exp_pc = pt & ~32'h3;
         else if (cons) exp_pc = exp_pc + 32'd4;
         if (preq && !pa) begin
            chk("req_hold", 32'(imem_req), 32'd1);
            chk("addr_hold", imem_addr, paddr);
         end
      end
      chk("valid", 32'(instr_valid), 32'(cnt > 0));
      chk("pc", instr_pc, (cnt > 0) ? exp_pc : 32'h0);
      chk("instr", instr, (cnt > 0) ? memw(exp_pc) : 32'h0);
   endtask

   task automatic run(input bit r, input bit s, input bit b,
                      input logic [31:0] t, input bit a);
      drive(r, s, b, t, a);
      step();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, 32'(imem_req), 32'd0);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_instr"}, instr, 32'h0);
      chk({tag, "_pc"}, instr_pc, 32'h0);
   endtask

   initial begin
      imem_ack = 1'b0;
      drive(1, 0, 0, 0, 0);
      run(1, 0, 0, 0, 0);
      run(1, 0, 0, 0, 0);
      chk_reset("rst");

      run(0, 0, 0, 0, 1);
      chk("first_req", 32'(imem_req), 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      run(0, 0, 0, 0, 1);
      chk("ipc0", instr_pc, 32'h0);
      run(0, 0, 0, 0, 1);
      chk("ipc1", instr_pc, 32'h4);
      run(0, 0, 0, 0, 1);
      chk("ipc2", instr_pc, 32'h8);
      chk("ipc_valid", 32'(instr_valid), 32'd1);

      for (int i = 0; i < 3; i++) begin
         run(0, 1, 0, 0, 1);
         chk("stall_req", 32'(imem_req), 32'd0);
         chk("stall_pc", instr_pc, 32'h8);
      end
      run(0, 0, 0, 0, 1);
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", imem_addr, 32'h10);
      chk("resume_pc", instr_pc, 32'hC);

      run(0, 1, 0, 0, 0);
      run(0, 0, 1, 32'h103, 0);
      chk("drop_valid", 32'(instr_valid), 32'd0);
      chk("drop_req", 32'(imem_req), 32'd1);
      chk("drop_addr", imem_addr, 32'h10);
      run(0, 0, 0, 0, 1);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_valid", 32'(instr_valid), 32'd0);
      run(0, 0, 0, 0, 1);
      chk("redir_pc", instr_pc, 32'h100);

      run(0, 0, 1, 32'h200, 1);
      chk("brack_addr", imem_addr, 32'h200);
      chk("brack_valid", 32'(instr_valid), 32'd0);

      run(0, 0, 1, 32'hFFFF_FFFF, 0);
      run(0, 0, 0, 0, 1);
      chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
      run(0, 0, 0, 0, 1);
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);

      run(0, 1, 0, 0, 1);
      run(1, 0, 0, 0, 1);
      chk_reset("rstfull");
      run(0, 0, 0, 0, 0);
      run(0, 0, 0, 0, 0);
      run(1, 1, 1, 32'h40, 1);
      chk_reset("rstwait");

      for (int i = 0; i < 800; i++) begin
         run(($urandom % 97) == 0, ($urandom % 10) < 3,
             ($urandom % 20) == 0, $urandom, ($urandom % 10) < 6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
